// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch predictor table.
//   - bp_state_e       : sweep FSM states (BP_INIT clears the table, BP_RUN serves it)
//   - bp_tag_w()       : tag width derived from PC and index widths (word-aligned PCs)
//   - bp_depth()       : table depth from index width
//   - ctr_weak_taken() : weak-taken counter encoding (MSB set, rest clear)
// The entry layout depends on the module parameters, so the entry struct is
// declared inside branch_predictor_table using these helpers.
package bp_pkg;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  function automatic int bp_tag_w(input int pc_w, input int idx_w);
    return pc_w - idx_w - 2;
  endfunction

  function automatic int bp_depth(input int idx_w);
    return 1 << idx_w;
  endfunction

  // Caller truncates to its CTR_W.
  function automatic logic [31:0] ctr_weak_taken(input int ctr_w);
    return 32'(1) << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: combinational CTR_W-bit saturating up/down counter step.
//   i_ctr   : current counter value
//   i_taken : 1 = count up, 0 = count down
//   o_ctr   : next value; sticks at all-ones on taken and at zero on not-taken
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_taken,
  output logic [CTR_W-1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (!(&i_ctr)) o_ctr = i_ctr + CTR_W'(1);
    end else begin
      if (|i_ctr) o_ctr = i_ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_table.sv
// branch_predictor_table: direct-mapped branch target buffer with saturating
// direction counters for the fetch stage.
//   Clk, Reset          : clock, asynchronous active-low reset
//   i_lookup_pc         : fetch PC (combinational lookup)
//   o_hit/o_taken       : valid tag match / match with counter MSB set
//   o_target            : stored target when taken, else i_lookup_pc+4
//   o_ready             : post-reset sweep finished
//   i_upd_valid/_pc/_taken/_target : resolved branch from EX
// Updates run through a two-stage pipeline: S1 registers the request, S2 reads
// the entry, computes the new one and writes it at the following edge.
// After reset an INIT sweep clears one entry per cycle before o_ready rises.
// Optional feature macro BP_GLOBAL_HISTORY_EN: adds a global history register
// whose value is XORed into the counter index (gshare-style); tags and targets
// stay indexed by the plain PC index.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 10,
  parameter int CTR_W = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [PC_W-1:0] i_lookup_pc,
  output logic            o_hit,
  output logic            o_taken,
  output logic [PC_W-1:0] o_target,
  output logic            o_ready,
  input  logic            i_upd_valid,
  input  logic [PC_W-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [PC_W-1:0] i_upd_target
);

  localparam int TAG_W = bp_tag_w(PC_W, IDX_W);
  localparam int DEPTH = bp_depth(IDX_W);
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(ctr_weak_taken(CTR_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } meta_t;

  // Storage: no reset, the sweep clears valid and counters.
  meta_t            mem_meta_q [DEPTH];
  logic [CTR_W-1:0] mem_ctr_q  [DEPTH];

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             sweep_we;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= BP_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      BP_INIT: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (&ptr_q) state_d = BP_RUN;
      end
      BP_RUN:  state_d = BP_RUN;
      default: state_d = BP_INIT;
    endcase
  end

  always_comb begin
    sweep_we = (state_q == BP_INIT);
    o_ready  = (state_q == BP_RUN);
  end

  // ---------------------------------------------------------------------------
  // S1: request register (PC kept without the ignored byte-offset bits)
  // ---------------------------------------------------------------------------
  logic            s1_vld_q, s1_vld_d;
  logic [PC_W-3:0] s1_pc_q, s1_pc_d;
  logic            s1_taken_q, s1_taken_d;
  logic [PC_W-1:0] s1_target_q, s1_target_d;
  logic            upd_accept;
  logic            unused_upd_pc_lsb;

  assign unused_upd_pc_lsb = ^i_upd_pc[1:0];
  // Updates during INIT are dropped, not queued.
  assign upd_accept = i_upd_valid & o_ready;

  always_comb begin
    s1_vld_d    = upd_accept;
    s1_pc_d     = upd_accept ? i_upd_pc[PC_W-1:2] : s1_pc_q;
    s1_taken_d  = upd_accept ? i_upd_taken        : s1_taken_q;
    s1_target_d = upd_accept ? i_upd_target       : s1_target_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_vld_q    <= 1'b0;
      s1_pc_q     <= '0;
      s1_taken_q  <= 1'b0;
      s1_target_q <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_pc_q     <= s1_pc_d;
      s1_taken_q  <= s1_taken_d;
      s1_target_q <= s1_target_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Index generation (with optional global history)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] s2_idx, s2_cidx, lk_idx, lk_cidx;
  logic [TAG_W-1:0] s2_tag, lk_tag;

  assign s2_idx = s1_pc_q[IDX_W-1:0];
  assign s2_tag = s1_pc_q[PC_W-3:IDX_W];
  assign lk_idx = i_lookup_pc[IDX_W+1:2];
  assign lk_tag = i_lookup_pc[PC_W-1:IDX_W+2];

`ifdef BP_GLOBAL_HISTORY_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0] s1_ghr_q, s1_ghr_d;

  // History is captured at acceptance so the counter index is stable across
  // the pipeline; it shifts once per update leaving S2, hit or miss.
  always_comb begin
    s1_ghr_d = upd_accept ? ghr_q : s1_ghr_q;
    ghr_d    = ghr_q;
    if (s1_vld_q) ghr_d = {ghr_q[IDX_W-2:0], s1_taken_q};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ghr_q    <= '0;
      s1_ghr_q <= '0;
    end else begin
      ghr_q    <= ghr_d;
      s1_ghr_q <= s1_ghr_d;
    end
  end

  assign s2_cidx = s2_idx ^ s1_ghr_q;
  assign lk_cidx = lk_idx ^ ghr_q;
`else
  assign s2_cidx = s2_idx;
  assign lk_cidx = lk_idx;
`endif

  // ---------------------------------------------------------------------------
  // S2: read-modify-write
  // The array is read combinationally and the previous update's write lands
  // on the same edge that loads the next request into S1, so a back-to-back
  // update to the same index always reads the freshly written entry.
  // ---------------------------------------------------------------------------
  meta_t            s2_rd_meta, s2_wr_meta;
  logic [CTR_W-1:0] s2_rd_ctr, s2_ctr_sat, s2_wr_ctr;
  logic             s2_hit, s2_we;

  assign s2_rd_meta = mem_meta_q[s2_idx];
  assign s2_rd_ctr  = mem_ctr_q[s2_cidx];
  assign s2_hit     = s2_rd_meta.valid & (s2_rd_meta.tag == s2_tag);

  bp_sat_counter #(.CTR_W(CTR_W)) u_sat (
    .i_ctr   (s2_rd_ctr),
    .i_taken (s1_taken_q),
    .o_ctr   (s2_ctr_sat)
  );

  always_comb begin
    // Miss & not-taken leaves the table alone.
    s2_we             = s1_vld_q & (s2_hit | s1_taken_q);
    s2_wr_meta.valid  = 1'b1;
    s2_wr_meta.tag    = s2_tag;
    s2_wr_meta.target = s1_taken_q ? s1_target_q : s2_rd_meta.target;
    s2_wr_ctr         = s2_hit ? s2_ctr_sat : CTR_WEAK_T;
  end

  // ---------------------------------------------------------------------------
  // Single write port: sweep in INIT, S2 in RUN (never both)
  // ---------------------------------------------------------------------------
  logic             meta_we, ctr_we;
  logic [IDX_W-1:0] meta_widx, ctr_widx;
  meta_t            meta_wdata;
  logic [CTR_W-1:0] ctr_wdata;

  always_comb begin
    meta_we    = 1'b0;
    meta_widx  = s2_idx;
    meta_wdata = s2_wr_meta;
    ctr_we     = 1'b0;
    ctr_widx   = s2_cidx;
    ctr_wdata  = s2_wr_ctr;
    if (sweep_we) begin
      meta_we    = 1'b1;
      meta_widx  = ptr_q;
      meta_wdata = '0;
      ctr_we     = 1'b1;
      ctr_widx   = ptr_q;
      ctr_wdata  = '0;
    end else if (s2_we) begin
      meta_we = 1'b1;
      ctr_we  = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (meta_we) mem_meta_q[meta_widx] <= meta_wdata;
    if (ctr_we)  mem_ctr_q[ctr_widx]   <= ctr_wdata;
  end

  // ---------------------------------------------------------------------------
  // Lookup: bypass the pending S2 write so an update is visible the cycle
  // after it is accepted.
  // ---------------------------------------------------------------------------
  meta_t            lk_meta;
  logic [CTR_W-1:0] lk_ctr;

  always_comb begin
    lk_meta = mem_meta_q[lk_idx];
    if (s2_we && (s2_idx == lk_idx)) lk_meta = s2_wr_meta;
    lk_ctr = mem_ctr_q[lk_cidx];
    if (s2_we && (s2_cidx == lk_cidx)) lk_ctr = s2_wr_ctr;

    o_hit    = o_ready & lk_meta.valid & (lk_meta.tag == lk_tag);
    o_taken  = o_hit & lk_ctr[CTR_W-1];
    o_target = o_taken ? lk_meta.target : i_lookup_pc + PC_W'(4);
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// tb_branch_predictor_table: directed self-checking bench for
// branch_predictor_table at default parameters (DEPTH = 1024, CTR_W = 2).
module tb_branch_predictor_table;

  localparam int DEPTH = 1024;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] i_lookup_pc = '0;
  logic        o_hit, o_taken, o_ready;
  logic [31:0] o_target;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_pc = '0;
  logic        i_upd_taken = 1'b0;
  logic [31:0] i_upd_target = '0;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  branch_predictor_table dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .i_lookup_pc  (i_lookup_pc),
    .o_hit        (o_hit),
    .o_taken      (o_taken),
    .o_target     (o_target),
    .o_ready      (o_ready),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_taken  (i_upd_taken),
    .i_upd_target (i_upd_target)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] tgt);
    i_lookup_pc = pc;
    #1;
    chk({tag, "_hit"},    32'(o_hit),   32'(hit));
    chk({tag, "_taken"},  32'(o_taken), 32'(taken));
    chk({tag, "_target"}, o_target,     tgt);
  endtask

  // One-cycle update; the request is accepted at the edge inside step().
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    i_upd_valid  = 1'b1;
    i_upd_pc     = pc;
    i_upd_taken  = tk;
    i_upd_target = tgt;
    step();
  endtask

  // Counts cycles until o_ready, injecting one update early in the sweep and
  // watching o_hit for the lookup PC 0x00400010.
  task automatic sweep(output int n, output bit saw_hit);
    n = 0;
    saw_hit = 1'b0;
    i_lookup_pc = 32'h0040_0010;
    while (!o_ready && n < 3000) begin
      if (n == 5) begin
        i_upd_valid  = 1'b1;
        i_upd_pc     = 32'h0040_0010;
        i_upd_taken  = 1'b1;
        i_upd_target = 32'h0040_0100;
      end else begin
        i_upd_valid = 1'b0;
      end
      step();
      n++;
      if (o_hit) saw_hit = 1'b1;
    end
    i_upd_valid = 1'b0;
  endtask

  int n;
  bit saw;

  initial begin
    // 1. reset state and INIT sweep
    #2;
    look("rst", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    chk("rst_ready", 32'(o_ready), 32'd0);
    step();
    step();
    Reset = 1'b1;
    sweep(n, saw);
    chk("init_len", n, DEPTH);
    chk("init_hit", 32'(saw), 32'd0);
    chk("init_ready", 32'(o_ready), 32'd1);
    look("init_upd_dropped", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);

    // 2. allocate, visible next cycle via forwarding, then from the array
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    i_upd_valid = 1'b0;
    look("alloc_fwd", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    step();
    look("alloc_arr", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);

    // 3. not-taken x3 back-to-back: 10 -> 01 -> 00 -> 00
    upd(32'h0040_0010, 1'b0, 32'h0);
    look("nt1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b0, 32'h0);
    look("nt2", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b0, 32'h0);
    look("nt3", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);

    // 4. taken x4 back-to-back: 00 -> 01 -> 10 -> 11 -> 11, then not-taken
    //    x2: 11 -> 10 (still taken) -> 01; a lost update shows up here
    upd(32'h0040_0010, 1'b1, 32'h0040_0200);
    look("tk1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b1, 32'h0040_0200);
    look("tk2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
    upd(32'h0040_0010, 1'b1, 32'h0040_0200);
    look("tk3", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
    upd(32'h0040_0010, 1'b1, 32'h0040_0200);
    look("tk4_sat", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
    upd(32'h0040_0010, 1'b0, 32'h0);
    look("sat_dn1", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
    upd(32'h0040_0010, 1'b0, 32'h0);
    look("sat_dn2", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    i_upd_valid = 1'b0;
    step();

    // 5. alias on same index, other tag
    look("alias_miss", 32'h0040_1010, 1'b0, 1'b0, 32'h0040_1014);
    upd(32'h0040_1010, 1'b0, 32'hDEAD_0000);
    i_upd_valid = 1'b0;
    step();
    look("alias_nt_nowr", 32'h0040_1010, 1'b0, 1'b0, 32'h0040_1014);
    look("orig_kept", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    upd(32'h0040_1010, 1'b1, 32'h0040_2000);
    i_upd_valid = 1'b0;
    look("alias_alloc", 32'h0040_1010, 1'b1, 1'b1, 32'h0040_2000);
    look("orig_evicted", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);

    // different indices back-to-back, both applied
    upd(32'h0040_0040, 1'b1, 32'h0050_0000);
    upd(32'h0040_0080, 1'b1, 32'h0060_0000);
    i_upd_valid = 1'b0;
    step();
    look("b2b_a", 32'h0040_0040, 1'b1, 1'b1, 32'h0050_0000);
    look("b2b_b", 32'h0040_0080, 1'b1, 1'b1, 32'h0060_0000);

    // pc+4 wraps
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    // 6. reset in the middle of an update stream
    upd(32'h0040_00C0, 1'b1, 32'h0070_0000);
    Reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(o_ready), 32'd0);
    look("mid_rst", 32'h0040_00C0, 1'b0, 1'b0, 32'h0040_00C4);
    step();
    step();
    Reset = 1'b1;
    sweep(n, saw);
    chk("reinit_len", n, DEPTH);
    chk("reinit_hit", 32'(saw), 32'd0);
    look("reinit_drop", 32'h0040_00C0, 1'b0, 1'b0, 32'h0040_00C4);
    look("reinit_clr", 32'h0040_0040, 1'b0, 1'b0, 32'h0040_0044);
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    i_upd_valid = 1'b0;
    look("post_rst_upd", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
